bdd_traversal_ctrl: RTL and testbench

- Sequencer for the decision-diagram inference datapath. Walks the tree from a root node.
- For each node it:
  - fetches the node word (coefficients, threshold, child pointers) from node memory,
  - drives an external multiply-accumulate unit over all features,
  - compares the accumulated value against the node threshold,
  - follows the selected child pointer.
- Stops at a leaf and reports the class id. Sits between the feature input stage and the node-memory/MAC resources.

---
 rtl/bdd_traversal_ctrl_if.sv | 41 ++++
 rtl/bdd_traversal_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_bdd_traversal_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bdd_traversal_ctrl_if.sv
// ---------------------------------------------------------------------------
// bdd_traversal_ctrl_if
// Resource-side bus of the decision-diagram traversal sequencer: the
// node-memory read port and the external multiply-accumulate unit.
//
//   node_en / node_addr      : node memory read request (controller -> mem)
//   node_coef/thr/child      : node word, valid the cycle after node_en
//   mac_ce / mac_load        : MAC beat enable; load marks the first beat
//   mac_mult / mac_coef      : feature (unsigned) and coefficient (signed)
//   mac_p                    : accumulated result, MAC_LAT cycles after a beat
//
// Modports: master = traversal controller, slave = memory/MAC side.
// ---------------------------------------------------------------------------
interface bdd_traversal_ctrl_if #(
  parameter int NUM_FEAT = 5,
  parameter int FEAT_W   = 8,
  parameter int COEF_W   = 8,
  parameter int ACC_W    = 24,
  parameter int ADDR_W   = 11
);
  logic                           node_en;
  logic        [ADDR_W-1:0]       node_addr;
  logic        [NUM_FEAT*COEF_W-1:0] node_coef;
  logic signed [ACC_W-1:0]        node_thr;
  logic        [2*(ADDR_W+1)-1:0] node_child;
  logic                           mac_ce;
  logic                           mac_load;
  logic        [FEAT_W-1:0]       mac_mult;
  logic signed [COEF_W-1:0]       mac_coef;
  logic signed [ACC_W-1:0]        mac_p;

  modport master (
    output node_en, node_addr, mac_ce, mac_load, mac_mult, mac_coef,
    input  node_coef, node_thr, node_child, mac_p
  );

  modport slave (
    input  node_en, node_addr, mac_ce, mac_load, mac_mult, mac_coef,
    output node_coef, node_thr, node_child, mac_p
  );
endinterface

// File: rtl/bdd_traversal_ctrl.sv
// ---------------------------------------------------------------------------
// bdd_traversal_ctrl
// Walks a decision diagram from a root node. Per internal node it reads the
// node word, streams NUM_FEAT feature/coefficient beats into an external MAC,
// waits out the MAC latency, compares the sum against the node threshold and
// follows the chosen child until a leaf (class id) or the depth limit.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : begin classification (accepted in IDLE only)
//   feat, root_addr : sample features and root node, captured on start
//   busy            : high from acceptance through the done cycle
//   done            : one-cycle result strobe
//   class_out, err  : leaf class / depth-abort flag, held until next start
//   bus             : node memory + MAC resource bus (master side)
// ---------------------------------------------------------------------------
module bdd_traversal_ctrl #(
  parameter int NUM_FEAT  = 5,
  parameter int FEAT_W    = 8,
  parameter int COEF_W    = 8,
  parameter int ACC_W     = 24,
  parameter int ADDR_W    = 11,
  parameter int MAC_LAT   = 3,
  parameter int MAX_DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_FEAT*FEAT_W-1:0] feat,
  input  logic [ADDR_W-1:0]          root_addr,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_W-1:0]          class_out,
  output logic                       err,
  bdd_traversal_ctrl_if.master       bus
);

  localparam int CNT_MAX = (NUM_FEAT > MAC_LAT) ? NUM_FEAT : MAC_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DEP_W   = $clog2(MAX_DEPTH + 1);

  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(NUM_FEAT - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN  = CNT_W'((MAC_LAT > 1) ? MAC_LAT - 2 : 0);
  localparam logic [DEP_W-1:0] DEPTH_LIMIT = DEP_W'(MAX_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_LATCH, ST_MAC, ST_DRAIN, ST_DECIDE, ST_DONE
  } state_t;

  state_t state, state_n;

  logic        [CNT_W-1:0]  beat;
  logic        [DEP_W-1:0]  depth;
  logic        [DEP_W-1:0]  depth_inc;
  logic        [ADDR_W-1:0] cur_node;
  logic        [ADDR_W-1:0] class_q;
  logic                     err_q;
  logic        [FEAT_W-1:0] feat_q [NUM_FEAT];
  logic signed [COEF_W-1:0] coef_q [NUM_FEAT];
  logic signed [ACC_W-1:0]  thr_q;
  logic        [ADDR_W:0]   child_hi;
  logic        [ADDR_W:0]   child_lo;
  logic        [ADDR_W:0]   sel_child;
  logic                     gt;
  logic        [FEAT_W-1:0] feat_sel;
  logic signed [COEF_W-1:0] coef_sel;
  logic        [FEAT_W-1:0] mult_hold;
  logic signed [COEF_W-1:0] coef_hold;

  // Operand mux for the current beat
  always_comb begin
    feat_sel = '0;
    coef_sel = '0;
    for (int k = 0; k < NUM_FEAT; k++) begin
      if (beat == CNT_W'(k)) begin
        feat_sel = feat_q[k];
        coef_sel = coef_q[k];
      end
    end
  end

  // Decision: strictly greater takes the hi child, ties go lo
  always_comb begin
    gt        = $signed(bus.mac_p) > $signed(thr_q);
    sel_child = gt ? child_hi : child_lo;
    depth_inc = depth + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n      = state;
    busy         = 1'b1;
    done         = 1'b0;
    bus.node_en  = 1'b0;
    bus.mac_ce   = 1'b0;
    bus.mac_load = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_n = ST_FETCH;
      end
      ST_FETCH: begin
        bus.node_en = 1'b1;
        state_n     = ST_LATCH;
      end
      ST_LATCH: state_n = ST_MAC;
      ST_MAC: begin
        bus.mac_ce   = 1'b1;
        bus.mac_load = (beat == '0);
        if (beat == LAST_BEAT) state_n = (MAC_LAT > 1) ? ST_DRAIN : ST_DECIDE;
      end
      ST_DRAIN: begin
        if (beat == LAST_DRAIN) state_n = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (sel_child[ADDR_W] || (depth_inc == DEPTH_LIMIT)) state_n = ST_DONE;
        else                                                  state_n = ST_FETCH;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // Operands are live during beats and frozen on the last beat otherwise
  always_comb begin
    bus.mac_mult = (state == ST_MAC) ? feat_sel : mult_hold;
    bus.mac_coef = (state == ST_MAC) ? coef_sel : coef_hold;
  end

  assign bus.node_addr = cur_node;
  assign class_out     = class_q;
  assign err           = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat      <= '0;
      depth     <= '0;
      cur_node  <= '0;
      class_q   <= '0;
      err_q     <= 1'b0;
      thr_q     <= '0;
      child_hi  <= '0;
      child_lo  <= '0;
      mult_hold <= '0;
      coef_hold <= '0;
      for (int k = 0; k < NUM_FEAT; k++) begin
        feat_q[k] <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int k = 0; k < NUM_FEAT; k++) feat_q[k] <= feat[k*FEAT_W +: FEAT_W];
            cur_node <= root_addr;
            depth    <= '0;
            err_q    <= 1'b0;
            class_q  <= '0;
          end
        end
        ST_LATCH: begin
          for (int k = 0; k < NUM_FEAT; k++) coef_q[k] <= bus.node_coef[k*COEF_W +: COEF_W];
          thr_q    <= bus.node_thr;
          child_hi <= bus.node_child[2*ADDR_W+1 : ADDR_W+1];
          child_lo <= bus.node_child[ADDR_W:0];
          beat     <= '0;
        end
        ST_MAC: begin
          mult_hold <= feat_sel;
          coef_hold <= coef_sel;
          beat      <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
        end
        ST_DRAIN: beat <= beat + 1'b1;
        ST_DECIDE: begin
          if (sel_child[ADDR_W]) begin
            class_q <= sel_child[ADDR_W-1:0];
          end else begin
            depth <= depth_inc;
            if (depth_inc == DEPTH_LIMIT) begin
              err_q   <= 1'b1;
              class_q <= '0;
            end else begin
              cur_node <= sel_child[ADDR_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bdd_traversal_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bdd_traversal_ctrl
// Bench for bdd_traversal_ctrl with a behavioural node memory and MAC.
// Expected results are queued at each accepted start and compared when done
// pulses (class, err, latency, busy).
// ---------------------------------------------------------------------------
module tb_bdd_traversal_ctrl;

  localparam int NF  = 5;
  localparam int FW  = 8;
  localparam int CW  = 8;
  localparam int AW  = 24;
  localparam int ADW = 11;
  localparam int ML  = 3;
  localparam int MD  = 4;

  typedef struct {
    logic [ADW-1:0] cls;
    logic           err;
    int             lat;
    int             t0;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [NF*FW-1:0] feat = '0;
  logic [ADW-1:0]   root_addr = '0;
  logic             busy, done, err;
  logic [ADW-1:0]   class_out;

  int tests_run = 0;
  int failures  = 0;
  int cyc       = 0;

  exp_t sb[$];
  logic [ADW-1:0] addr_q[$];
  int   ce_cnt = 0, load_cnt = 0, en_cnt = 0, done_cnt = 0;
  logic first_load = 1'b0;

  bdd_traversal_ctrl_if #(.NUM_FEAT(NF), .FEAT_W(FW), .COEF_W(CW), .ACC_W(AW), .ADDR_W(ADW)) bus ();

  bdd_traversal_ctrl #(
    .NUM_FEAT(NF), .FEAT_W(FW), .COEF_W(CW), .ACC_W(AW),
    .ADDR_W(ADW), .MAC_LAT(ML), .MAX_DEPTH(MD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .feat(feat), .root_addr(root_addr),
    .busy(busy), .done(done), .class_out(class_out), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Node memory: one-cycle read latency
  logic        [NF*CW-1:0]     mem_coef  [16];
  logic signed [AW-1:0]        mem_thr   [16];
  logic        [2*(ADW+1)-1:0] mem_child [16];

  always @(posedge clk) begin
    if (bus.node_en) begin
      bus.node_coef  <= mem_coef[bus.node_addr[3:0]];
      bus.node_thr   <= mem_thr[bus.node_addr[3:0]];
      bus.node_child <= mem_child[bus.node_addr[3:0]];
    end
  end

  // MAC: accumulate on the beat edge, then ML-1 further register stages
  logic signed [AW-1:0] acc = '0, p1 = '0, p2 = '0, prod;
  always_comb prod = $signed({{(AW-FW){1'b0}}, bus.mac_mult}) *
                     $signed({{(AW-CW){bus.mac_coef[CW-1]}}, bus.mac_coef});
  always @(posedge clk) begin
    if (bus.mac_ce) acc <= bus.mac_load ? prod : acc + prod;
    p1 <= acc;
    p2 <= p1;
  end
  assign bus.mac_p = p2;

  // Monitor and scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (bus.mac_ce) begin
      if (ce_cnt == 0) first_load = bus.mac_load;
      ce_cnt++;
      if (bus.mac_load) load_cnt++;
    end
    if (bus.node_en) begin
      en_cnt++;
      addr_q.push_back(bus.node_addr);
    end
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        tests_run++; failures++;
        $display("FAIL unexpected_done: done=1 with no result pending at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        tests_run++;
        if (class_out !== e.cls) begin
          failures++;
          $display("FAIL class_out: got %0d expected %0d", class_out, e.cls);
        end
        tests_run++;
        if (err !== e.err) begin
          failures++;
          $display("FAIL err: got %0b expected %0b", err, e.err);
        end
        tests_run++;
        if ((cyc - e.t0) !== e.lat) begin
          failures++;
          $display("FAIL latency: got %0d expected %0d", cyc - e.t0, e.lat);
        end
        tests_run++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_at_done: got %0b expected 1", busy);
        end
      end
    end
  end

  function automatic logic [ADW:0] leaf(input int c);
    return {1'b1, ADW'(c)};
  endfunction

  function automatic logic [ADW:0] inode(input int a);
    return {1'b0, ADW'(a)};
  endfunction

  function automatic logic [NF*FW-1:0] ramp(input int base);
    logic [NF*FW-1:0] f;
    for (int k = 0; k < NF; k++) f[k*FW +: FW] = FW'(base + k);
    return f;
  endfunction

  task automatic set_node(input int a, input int c, input int thr,
                          input logic [ADW:0] hi, input logic [ADW:0] lo);
    logic [NF*CW-1:0] w;
    for (int k = 0; k < NF; k++) w[k*CW +: CW] = CW'(c);
    mem_coef[a]  = w;
    mem_thr[a]   = AW'(thr);
    mem_child[a] = {hi, lo};
  endtask

  task automatic clear_mon();
    ce_cnt = 0; load_cnt = 0; en_cnt = 0; first_load = 1'b0;
    addr_q.delete();
  endtask

  task automatic start_run(input logic [NF*FW-1:0] f, input int root,
                           input int cls, input logic e_err, input int lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1; feat = f; root_addr = ADW'(root);
    @(negedge clk);
    start = 1'b0;
    e.cls = ADW'(cls); e.err = e_err; e.lat = lat; e.t0 = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == d0) begin
      tests_run++; failures++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, err, class_out, bus.node_en, bus.node_addr, bus.mac_ce,
         bus.mac_load, bus.mac_mult, bus.mac_coef} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b class=%0d node_en=%0b mac_ce=%0b expected all 0",
               busy, done, err, class_out, bus.node_en, bus.mac_ce);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%0b done=%0b expected 0 0", busy, done);
    end
  endtask

  task automatic test_single_node();
    set_node(0, 1, 10, leaf(7), leaf(3));
    clear_mon();
    start_run(ramp(1), 0, 7, 1'b0, 10);
    wait_done();
    @(negedge clk); #1;
    tests_run++;
    if (load_cnt !== 1 || first_load !== 1'b1) begin
      failures++;
      $display("FAIL mac_load: count=%0d first=%0b expected 1 1", load_cnt, first_load);
    end
    tests_run++;
    if (ce_cnt !== NF) begin
      failures++;
      $display("FAIL mac_beats: got %0d expected %0d", ce_cnt, NF);
    end
    tests_run++;
    if (en_cnt !== 1) begin
      failures++;
      $display("FAIL node_reads: got %0d expected 1", en_cnt);
    end
    tests_run++;
    if (bus.mac_mult !== 8'd5 || bus.mac_coef !== 8'sd1) begin
      failures++;
      $display("FAIL operand_hold: mult=%0d coef=%0d expected 5 1", bus.mac_mult, bus.mac_coef);
    end
    tests_run++;
    if (busy !== 1'b0 || bus.node_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_done: busy=%0b node_en=%0b expected 0 0", busy, bus.node_en);
    end
  endtask

  task automatic test_equality();
    set_node(0, 1, 15, leaf(7), leaf(3));
    start_run(ramp(1), 0, 3, 1'b0, 10);
    wait_done();
  endtask

  task automatic test_two_level();
    set_node(0, -1, 0, leaf(1), inode(4));
    set_node(4, 2, 20, leaf(9), leaf(5));
    clear_mon();
    start_run(ramp(1), 0, 9, 1'b0, 20);
    wait_done();
    tests_run++;
    if (addr_q.size() != 2) begin
      failures++;
      $display("FAIL node_addr_count: got %0d expected 2", addr_q.size());
    end else if (addr_q[0] !== 11'd0 || addr_q[1] !== 11'd4) begin
      failures++;
      $display("FAIL node_addr_seq: got %0d,%0d expected 0,4", addr_q[0], addr_q[1]);
    end
  endtask

  task automatic test_loop_abort();
    set_node(2, 0, 0, inode(2), inode(2));
    clear_mon();
    start_run(ramp(1), 2, 0, 1'b1, 4 * 10);
    wait_done();
    tests_run++;
    if (en_cnt !== MD) begin
      failures++;
      $display("FAIL abort_visits: got %0d expected %0d", en_cnt, MD);
    end
  endtask

  task automatic test_start_busy();
    set_node(0, 1, 10, leaf(7), leaf(3));
    set_node(5, 0, 0, leaf(12), leaf(12));
    clear_mon();
    start_run(ramp(1), 0, 7, 1'b0, 10);
    repeat (3) @(negedge clk);
    start = 1'b1; feat = '0; root_addr = 11'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    tests_run++;
    if (en_cnt !== 1) begin
      failures++;
      $display("FAIL busy_start_side_effect: node reads %0d expected 1", en_cnt);
    end
  endtask

  task automatic test_back_to_back();
    set_node(0, 1, 10, leaf(7), leaf(3));
    start_run(ramp(1), 0, 7, 1'b0, 10);
    wait_done();
    start_run(ramp(0), 0, 3, 1'b0, 10);
    wait_done();
  endtask

  task automatic test_reset_mid_mac();
    int n = 0;
    set_node(0, 1, 10, leaf(7), leaf(3));
    clear_mon();
    start_run(ramp(1), 0, 7, 1'b0, 10);
    while (ce_cnt < 3 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.mac_ce !== 1'b0) begin
      failures++;
      $display("FAIL reset_mac_ce: got %0b expected 0", bus.mac_ce);
    end
    tests_run++;
    if ({busy, done, err, class_out, bus.node_en, bus.node_addr,
         bus.mac_load, bus.mac_mult, bus.mac_coef} !== '0) begin
      failures++;
      $display("FAIL reset_mid_mac_outputs: busy=%0b mult=%0d coef=%0d expected all 0",
               busy, bus.mac_mult, bus.mac_coef);
    end
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    start_run(ramp(1), 0, 7, 1'b0, 10);
    wait_done();
  endtask

  initial begin
    test_reset();
    test_single_node();
    test_equality();
    test_two_level();
    test_loop_abort();
    test_start_busy();
    test_back_to_back();
    test_reset_mid_mac();
    repeat (2) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending_results: %0d results never reported, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
